// File: rtl/alu_if.sv
// ALU operand/result bundle: master drives op select and operands, slave returns result, zero flag and status.
// Pure wiring; carries no state and no flow control.
interface alu_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       ctrl;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic [WIDTH-1:0] rd;
    logic             z;
    logic [3:0]       flags;

    modport master (
        output ctrl, rs1, rs2,
        input  rd, z, flags
    );

    modport slave (
        input  ctrl, rs1, rs2,
        output rd, z, flags
    );
endinterface

// File: rtl/alu.sv
// Integer ALU for the execute stage with a clocked {N,Z,C,V} status snapshot; shifter built only with ALU_SHIFT_EN.
// Latency: rd/z combinational (0 cycles); flags registered, 1 cycle after the operands settle.
// Backpressure: none; a new operation is accepted every cycle and the status register always captures.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
`ifdef ALU_SHIFT_EN
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;
    localparam int         SHW    = $clog2(WIDTH);
`endif
    localparam int         MSB    = WIDTH - 1;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] rd_c;
    logic             z_c;
    logic             c_c;
    logic             v_c;
    logic [3:0]       flags_d;
    logic [3:0]       flags_q;

    always_comb begin
        sum_ext  = {1'b0, bus.rs1} + {1'b0, bus.rs2};
        diff_ext = {1'b0, bus.rs1} - {1'b0, bus.rs2};
        rd_c     = '0;
        c_c      = 1'b0;
        v_c      = 1'b0;
        case (bus.ctrl)
            OP_ADD: begin
                rd_c = sum_ext[WIDTH-1:0];
                c_c  = sum_ext[WIDTH];
                v_c  = (bus.rs1[MSB] == bus.rs2[MSB]) && (sum_ext[MSB] != bus.rs1[MSB]);
            end
            OP_SUB: begin
                rd_c = diff_ext[WIDTH-1:0];
                // Top bit of the extended difference is the borrow; carry is its inverse.
                c_c  = ~diff_ext[WIDTH];
                v_c  = (bus.rs1[MSB] != bus.rs2[MSB]) && (diff_ext[MSB] != bus.rs1[MSB]);
            end
            OP_AND: rd_c = bus.rs1 & bus.rs2;
            OP_OR:  rd_c = bus.rs1 | bus.rs2;
            OP_XOR: rd_c = bus.rs1 ^ bus.rs2;
            OP_SLT: rd_c = {{(WIDTH-1){1'b0}}, ($signed(bus.rs1) < $signed(bus.rs2))};
`ifdef ALU_SHIFT_EN
            OP_SLL: rd_c = bus.rs1 << bus.rs2[SHW-1:0];
            OP_SRL: rd_c = bus.rs1 >> bus.rs2[SHW-1:0];
`endif
            default: rd_c = '0;
        endcase
        z_c     = (rd_c == '0);
        flags_d = {rd_c[MSB], z_c, c_c, v_c};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign bus.rd    = rd_c;
    assign bus.z     = z_c;
    assign bus.flags = flags_q;
endmodule

// File: tb/tb_alu.sv
// Bench for alu: vector table for the combinational result, scoreboard queue for the registered flags.
module tb_alu;
    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] rd;
        logic        z;
        logic [3:0]  flags;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    logic [3:0] exp_flags_q[$];
    vec_t vecs[17];

    alu_if #(.WIDTH(32)) bus ();

    alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic pop_flags(input string name);
        if (exp_flags_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty, got 0x%0h expected an entry", name, bus.flags);
        end else begin
            check(name, {28'd0, bus.flags}, {28'd0, exp_flags_q.pop_front()});
        end
    endtask

    task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        bus.ctrl = c;
        bus.rs1  = a;
        bus.rs2  = b;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        drive(3'b000, 32'd0, 32'd0);

        vecs[0]  = '{3'b000, 32'd20,        32'd30,        32'd50,        1'b0, 4'b0000};
        vecs[1]  = '{3'b001, 32'd8,         32'd3,         32'd5,         1'b0, 4'b0010};
        vecs[2]  = '{3'b010, 32'd20,        32'd30,        32'd20,        1'b0, 4'b0000};
        vecs[3]  = '{3'b011, 32'd20,        32'd30,        32'd30,        1'b0, 4'b0000};
        vecs[4]  = '{3'b001, 32'd20,        32'd20,        32'd0,         1'b1, 4'b0110};
        vecs[5]  = '{3'b101, 32'hFFFFFFFF,  32'd1,         32'd1,         1'b0, 4'b0000};
        vecs[6]  = '{3'b101, 32'd20,        32'd30,        32'd1,         1'b0, 4'b0000};
        vecs[7]  = '{3'b101, 32'd30,        32'd20,        32'd0,         1'b1, 4'b0100};
        vecs[8]  = '{3'b000, 32'h7FFFFFFF,  32'd1,         32'h80000000,  1'b0, 4'b1001};
        vecs[9]  = '{3'b000, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 4'b0110};
        vecs[10] = '{3'b001, 32'd0,         32'd1,         32'hFFFFFFFF,  1'b0, 4'b1000};
        vecs[11] = '{3'b100, 32'hF0F0F0F0,  32'hFF00FF00,  32'h0FF00FF0,  1'b0, 4'b0000};
        vecs[12] = '{3'b001, 32'h80000000,  32'd1,         32'h7FFFFFFF,  1'b0, 4'b0011};
        vecs[13] = '{3'b101, 32'h80000000,  32'h7FFFFFFF,  32'd1,         1'b0, 4'b0000};
`ifdef ALU_SHIFT_EN
        vecs[14] = '{3'b110, 32'd1,         32'h00000024,  32'h00000010,  1'b0, 4'b0000};
        vecs[15] = '{3'b111, 32'h80000000,  32'hFFFFFFFF,  32'd1,         1'b0, 4'b0000};
`else
        vecs[14] = '{3'b110, 32'd1,         32'h00000024,  32'd0,         1'b1, 4'b0100};
        vecs[15] = '{3'b111, 32'h80000000,  32'hFFFFFFFF,  32'd0,         1'b1, 4'b0100};
`endif
        vecs[16] = '{3'b001, 32'd5,         32'd8,         32'hFFFFFFFD,  1'b0, 4'b1000};

        // Held in reset with 0+0 on the inputs, which would otherwise capture Z=1.
        repeat (2) @(posedge clk);
        #1;
        check("reset flags", {28'd0, bus.flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].ctrl, vecs[i].rs1, vecs[i].rs2);
            #1;
            check($sformatf("v%0d rd", i), bus.rd, vecs[i].rd);
            check($sformatf("v%0d z", i), {31'd0, bus.z}, {31'd0, vecs[i].z});
            exp_flags_q.push_back(vecs[i].flags);
            @(posedge clk);
            #1;
            pop_flags($sformatf("v%0d flags", i));
        end

        // Same-cycle response to an operand change, no clock edge in between.
        @(negedge clk);
        drive(3'b000, 32'd1, 32'd2);
        #1;
        check("settle rd a", bus.rd, 32'd3);
        drive(3'b001, 32'd1, 32'd2);
        #1;
        check("settle rd b", bus.rd, 32'hFFFFFFFF);

        // Reset across a posedge while an overflowing add is presented.
        @(negedge clk);
        rst_n = 1'b0;
        drive(3'b000, 32'h7FFFFFFF, 32'd1);
        #1;
        check("rst rd", bus.rd, 32'h80000000);
        check("rst z", {31'd0, bus.z}, 32'd0);
        exp_flags_q.push_back(4'b0000);
        @(posedge clk);
        #1;
        pop_flags("rst flags");
        check("rst rd hold", bus.rd, 32'h80000000);
        @(negedge clk);
        rst_n = 1'b1;
        exp_flags_q.push_back(4'b1001);
        @(posedge clk);
        #1;
        pop_flags("post rst flags");

        if (exp_flags_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", exp_flags_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
